// File: rtl/eva_ahb_arb_if.sv
// eva_ahb_arb_if: requester-side and slave-side AHB-lite signals of the arbiter.
// Per-requester fields are packed side by side; slice i of each field belongs to requester i.
interface eva_ahb_arb_if #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
);
    // Requester side
    logic [NUM_M-1:0]    m_req;
    logic [2*NUM_M-1:0]  m_htrans;
    logic [NUM_M-1:0]    m_hwrite;
    logic [3*NUM_M-1:0]  m_hsize;
    logic [AW*NUM_M-1:0] m_haddr;
    logic [DW*NUM_M-1:0] m_hwdata;
    logic [NUM_M-1:0]    m_grant;
    logic [NUM_M-1:0]    m_dsel;
    logic                m_hready;
    logic [1:0]          m_hresp;
    logic [DW-1:0]       m_hrdata;

    // Slave side
    logic [1:0]          htrans;
    logic                hwrite;
    logic [2:0]          hsize;
    logic [AW-1:0]       haddr;
    logic [DW-1:0]       hwdata;
    logic                hready_in;
    logic [1:0]          hresp_in;
    logic [DW-1:0]       hrdata_in;

    logic [15:0]         arb_cnt;

    // Arbiter view
    modport slave (
        input  m_req, m_htrans, m_hwrite, m_hsize, m_haddr, m_hwdata,
        input  hready_in, hresp_in, hrdata_in,
        output m_grant, m_dsel, m_hready, m_hresp, m_hrdata,
        output htrans, hwrite, hsize, haddr, hwdata, arb_cnt
    );

    // Environment view: requesters plus the downstream slave
    modport master (
        output m_req, m_htrans, m_hwrite, m_hsize, m_haddr, m_hwdata,
        output hready_in, hresp_in, hrdata_in,
        input  m_grant, m_dsel, m_hready, m_hresp, m_hrdata,
        input  htrans, hwrite, hsize, haddr, hwdata, arb_cnt
    );
endinterface

// File: rtl/eva_ahb_arb.sv
// eva_ahb_arb: round-robin AHB-lite arbiter sharing one master port among NUM_M requesters.
// Address phase follows the registered grant; hwdata follows the separately tracked
// data-phase owner so a handover costs no dead cycle.
module eva_ahb_arb #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic         hclk,
    input  logic         rst_n,
    eva_ahb_arb_if.slave bus
);
    localparam int unsigned IW          = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [1:0]  HTRANS_IDLE = 2'b00;

    logic [NUM_M-1:0] r_grant;
    logic [NUM_M-1:0] r_dsel;
    logic [IW-1:0]    r_last;
    logic [15:0]      r_arb_cnt;

    logic [1:0]       w_htrans;
    logic             w_hwrite;
    logic [2:0]       w_hsize;
    logic [AW-1:0]    w_haddr;
    logic [DW-1:0]    w_hwdata;
    logic             w_own_req;
    logic             w_releasable;
    logic             w_found;
    logic [IW-1:0]    w_win;
    logic [NUM_M-1:0] w_win_oh;

    // Address-phase mux and the owner's request, selected by the registered grant.
    always_comb begin
        w_htrans  = HTRANS_IDLE;
        w_hwrite  = 1'b0;
        w_hsize   = '0;
        w_haddr   = '0;
        w_own_req = 1'b0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (r_grant[i]) begin
                w_htrans  = bus.m_htrans[2*i +: 2];
                w_hwrite  = bus.m_hwrite[i];
                w_hsize   = bus.m_hsize[3*i +: 3];
                w_haddr   = bus.m_haddr[AW*i +: AW];
                w_own_req = bus.m_req[i];
            end
        end
    end

    // Data-phase mux, selected by the data-phase owner.
    always_comb begin
        w_hwdata = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (r_dsel[i]) begin
                w_hwdata = bus.m_hwdata[DW*i +: DW];
            end
        end
    end

    // An owner mid-transfer (NONSEQ/SEQ/BUSY with request held) keeps the bus.
    assign w_releasable = (r_grant == '0) || (w_htrans == HTRANS_IDLE) || !w_own_req;

    // Circular search from last+1: first scan above last, then wrap to 0..last.
    always_comb begin
        w_found  = 1'b0;
        w_win    = r_last;
        w_win_oh = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!w_found && bus.m_req[i] && (i > 32'(r_last))) begin
                w_found     = 1'b1;
                w_win       = IW'(i);
                w_win_oh[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!w_found && bus.m_req[i] && (i <= 32'(r_last))) begin
                w_found     = 1'b1;
                w_win       = IW'(i);
                w_win_oh[i] = 1'b1;
            end
        end
    end

    // Grant, data-phase owner and change counter; all frozen while the slave stalls.
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            r_grant   <= '0;
            r_dsel    <= '0;
            r_last    <= IW'(NUM_M - 1);
            r_arb_cnt <= '0;
        end else if (bus.hready_in) begin
            r_dsel <= w_htrans[1] ? r_grant : '0;
            if (w_releasable) begin
                if (!w_found) begin
                    r_grant <= '0;
                end else if (w_win_oh != r_grant) begin
                    r_grant   <= w_win_oh;
                    r_last    <= w_win;
                    r_arb_cnt <= r_arb_cnt + 16'd1;
                end
            end
        end
    end

    assign bus.m_grant  = r_grant;
    assign bus.m_dsel   = r_dsel;
    assign bus.m_hready = bus.hready_in;
    assign bus.m_hresp  = bus.hresp_in;
    assign bus.m_hrdata = bus.hrdata_in;
    assign bus.htrans   = w_htrans;
    assign bus.hwrite   = w_hwrite;
    assign bus.hsize    = w_hsize;
    assign bus.haddr    = w_haddr;
    assign bus.hwdata   = w_hwdata;
    assign bus.arb_cnt  = r_arb_cnt;
endmodule

// File: tb/tb_eva_ahb_arb.sv
// tb_eva_ahb_arb: directed stimulus for a three-requester arbiter, checked every cycle
// against an ownership model plus hand-computed literal expectations.
module tb_eva_ahb_arb;
    localparam int unsigned NM = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic hclk  = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    // Per-requester stimulus
    bit            rq  [NM];
    logic [1:0]    trs [NM];
    logic          wr  [NM];
    logic [2:0]    sz  [NM];
    logic [AW-1:0] ad  [NM];
    logic [DW-1:0] wd  [NM];

    // Model: address owner, data owner (-1 = none), last owner, change count
    int          own  = -1;
    int          down = -1;
    int          lst  = int'(NM) - 1;
    int unsigned cnt  = 0;

    eva_ahb_arb_if #(.NUM_M(NM), .AW(AW), .DW(DW)) bus ();

    eva_ahb_arb #(.NUM_M(NM), .AW(AW), .DW(DW)) dut (
        .hclk  (hclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 hclk = ~hclk;

    // Pack the per-requester arrays onto the interface.
    always_comb begin
        bus.m_req    = '0;
        bus.m_htrans = '0;
        bus.m_hwrite = '0;
        bus.m_hsize  = '0;
        bus.m_haddr  = '0;
        bus.m_hwdata = '0;
        for (int i = 0; i < NM; i++) begin
            bus.m_req[i]              = rq[i];
            bus.m_htrans[2*i +: 2]    = trs[i];
            bus.m_hwrite[i]           = wr[i];
            bus.m_hsize[3*i +: 3]     = sz[i];
            bus.m_haddr[AW*i +: AW]   = ad[i];
            bus.m_hwdata[DW*i +: DW]  = wd[i];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [NM-1:0] onehot(input int x);
        return (x < 0) ? '0 : (NM'(1) << x);
    endfunction

    function automatic int idx_of(input logic [NM-1:0] g);
        for (int i = 0; i < NM; i++) if (g[i]) return i;
        return -1;
    endfunction

    // Ownership model: arbitrate at each unstalled edge from the stimulus arrays.
    always @(posedge hclk) begin : model
        int nxt;
        int dnew;
        int c;
        logic [1:0] bt;
        if (!rst_n) begin
            own  = -1;
            down = -1;
            lst  = int'(NM) - 1;
            cnt  = 0;
        end else if (bus.hready_in) begin
            bt   = (own >= 0) ? trs[own] : IDLE;
            dnew = bt[1] ? own : -1;
            if (own < 0 || bt == IDLE || !rq[own]) begin
                nxt = -1;
                for (int k = 1; k <= int'(NM); k++) begin
                    c = (lst + k) % int'(NM);
                    if (nxt < 0 && rq[c]) nxt = c;
                end
                if (nxt < 0) begin
                    own = -1;
                end else if (nxt != own) begin
                    own = nxt;
                    lst = nxt;
                    cnt = (cnt + 1) % 65536;
                end
            end
            down = dnew;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge hclk) begin
        if (chk_en) begin
            check("grant", 64'(bus.m_grant), 64'(onehot(own)));
            check("dsel", 64'(bus.m_dsel), 64'(onehot(down)));
            check("htrans", 64'(bus.htrans), (own >= 0) ? 64'(trs[own]) : 64'(0));
            check("hwrite", 64'(bus.hwrite), (own >= 0) ? 64'(wr[own]) : 64'(0));
            check("hsize", 64'(bus.hsize), (own >= 0) ? 64'(sz[own]) : 64'(0));
            check("haddr", 64'(bus.haddr), (own >= 0) ? 64'(ad[own]) : 64'(0));
            check("hwdata", 64'(bus.hwdata), (down >= 0) ? 64'(wd[down]) : 64'(0));
            check("arb_cnt", 64'(bus.arb_cnt), 64'(cnt));
            check("m_hready", 64'(bus.m_hready), 64'(bus.hready_in));
            check("m_hresp", 64'(bus.m_hresp), 64'(bus.hresp_in));
            check("m_hrdata", 64'(bus.m_hrdata), 64'(bus.hrdata_in));
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
        bus.hrdata_in = $urandom();
        bus.hresp_in  = 2'($urandom_range(1));
    endtask

    int            order [$];
    int            exp_ord [6] = '{0, 1, 2, 0, 1, 2};
    logic [NM-1:0] prev;
    bit            issued [NM];

    initial begin
        for (int i = 0; i < NM; i++) begin
            rq[i]  = 1'b0;
            trs[i] = IDLE;
            wr[i]  = (i != 2);
            sz[i]  = (i == 2) ? 3'd1 : 3'd2;
            ad[i]  = 32'h1000 * (i + 1);
            wd[i]  = 32'hA0 + i;
        end
        bus.hready_in = 1'b1;
        bus.hresp_in  = 2'b00;
        bus.hrdata_in = '0;

        // Reset
        step();
        step();
        chk_en = 1'b1;
        @(negedge hclk);
        check("rst_grant", 64'(bus.m_grant), 64'(0));
        check("rst_dsel", 64'(bus.m_dsel), 64'(0));
        check("rst_cnt", 64'(bus.arb_cnt), 64'(0));
        check("rst_htrans", 64'(bus.htrans), 64'(0));
        check("rst_hwdata", 64'(bus.hwdata), 64'(0));

        // Two simultaneous requests: 0 first, then 1 once 0 goes IDLE
        step();
        rst_n = 1'b1; rq[0] = 1'b1; rq[1] = 1'b1; trs[0] = NONSEQ; trs[1] = NONSEQ;
        @(negedge hclk);
        check("t1_pre_grant", 64'(bus.m_grant), 64'(0));
        step();
        @(negedge hclk);
        check("t1_grant0", 64'(bus.m_grant), 64'(3'b001));
        check("t1_htrans", 64'(bus.htrans), 64'(2'b10));
        check("t1_haddr", 64'(bus.haddr), 64'(32'h1000));
        step();
        trs[0] = IDLE;
        @(negedge hclk);
        check("t1_dsel0", 64'(bus.m_dsel), 64'(3'b001));
        check("t1_hwdata0", 64'(bus.hwdata), 64'(32'hA0));
        step();
        rq[0] = 1'b0; ad[1] = 32'h100; wr[1] = 1'b1;
        @(negedge hclk);
        check("t1_grant1", 64'(bus.m_grant), 64'(3'b010));
        check("t1_cnt", 64'(bus.arb_cnt), 64'(2));

        // 4-beat INCR write from 1; 0 requests from beat 2 and waits
        step();
        trs[1] = SEQ; ad[1] = 32'h104; wd[1] = 32'hD1;
        rq[0] = 1'b1; trs[0] = NONSEQ; ad[0] = 32'h200;
        @(negedge hclk);
        check("t2_grant_b2", 64'(bus.m_grant), 64'(3'b010));
        check("t2_hwdata_b1", 64'(bus.hwdata), 64'(32'hD1));
        step();
        ad[1] = 32'h108; wd[1] = 32'hD2;
        @(negedge hclk);
        check("t2_grant_b3", 64'(bus.m_grant), 64'(3'b010));
        check("t2_hwdata_b2", 64'(bus.hwdata), 64'(32'hD2));
        step();
        ad[1] = 32'h10C; wd[1] = 32'hD3; rq[1] = 1'b0;
        @(negedge hclk);
        check("t2_grant_b4", 64'(bus.m_grant), 64'(3'b010));
        check("t2_hwdata_b3", 64'(bus.hwdata), 64'(32'hD3));
        step();
        trs[1] = IDLE; wd[1] = 32'hD4;
        @(negedge hclk);
        check("t2_handover_grant", 64'(bus.m_grant), 64'(3'b001));
        check("t2_handover_dsel", 64'(bus.m_dsel), 64'(3'b010));
        check("t2_hwdata_b4", 64'(bus.hwdata), 64'(32'hD4));
        check("t2_haddr", 64'(bus.haddr), 64'(32'h200));
        check("t2_cnt", 64'(bus.arb_cnt), 64'(3));

        // Three wait states while requester 2 arrives
        step();
        trs[0] = IDLE; rq[0] = 1'b0; wd[0] = 32'hE0;
        rq[2] = 1'b1; trs[2] = NONSEQ; ad[2] = 32'h300;
        bus.hready_in = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (w > 0) step();
            if (w == 3) bus.hready_in = 1'b1;
            @(negedge hclk);
            check("t3_wait_grant", 64'(bus.m_grant), 64'(3'b001));
            check("t3_wait_dsel", 64'(bus.m_dsel), 64'(3'b001));
            check("t3_wait_cnt", 64'(bus.arb_cnt), 64'(3));
        end
        step();
        rq[0] = 1'b1; rq[1] = 1'b1; rq[2] = 1'b1;
        @(negedge hclk);
        check("t3_grant2", 64'(bus.m_grant), 64'(3'b100));
        check("t3_cnt", 64'(bus.arb_cnt), 64'(4));
        check("t3_haddr", 64'(bus.haddr), 64'(32'h300));

        // Round robin: each owner issues one NONSEQ then IDLE
        prev = bus.m_grant;
        issued[0] = 1'b0; issued[1] = 1'b0; issued[2] = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
            if (bus.m_grant != prev && bus.m_grant != '0) order.push_back(idx_of(bus.m_grant));
            prev = bus.m_grant;
            for (int i = 0; i < NM; i++) begin
                if (bus.m_grant[i] && !issued[i]) begin
                    trs[i]    = NONSEQ;
                    issued[i] = 1'b1;
                end else begin
                    trs[i] = IDLE;
                end
                if (!bus.m_grant[i]) issued[i] = 1'b0;
            end
        end
        @(negedge hclk);
        check("rr_len", 64'(order.size()), 64'(6));
        for (int j = 0; j < 6; j++) begin
            check("rr_order", (j < order.size()) ? 64'(order[j]) : 64'hFFFF, 64'(exp_ord[j]));
        end
        check("rr_cnt", 64'(bus.arb_cnt), 64'(10));

        // No requests
        step();
        for (int i = 0; i < NM; i++) begin
            rq[i]  = 1'b0;
            trs[i] = IDLE;
        end
        step();
        @(negedge hclk);
        check("idle_grant", 64'(bus.m_grant), 64'(0));
        check("idle_htrans", 64'(bus.htrans), 64'(0));
        check("idle_hwdata", 64'(bus.hwdata), 64'(0));

        // Reset in the middle of a burst from requester 1
        step();
        rq[1] = 1'b1; trs[1] = NONSEQ; ad[1] = 32'h400;
        step();
        trs[1] = SEQ; ad[1] = 32'h404;
        step();
        ad[1] = 32'h408; rst_n = 1'b0;
        @(negedge hclk);
        check("mid_grant", 64'(bus.m_grant), 64'(3'b010));
        check("mid_dsel", 64'(bus.m_dsel), 64'(3'b010));
        step();
        rst_n = 1'b1; rq[0] = 1'b1; rq[1] = 1'b1; trs[1] = IDLE;
        @(negedge hclk);
        check("mrst_grant", 64'(bus.m_grant), 64'(0));
        check("mrst_dsel", 64'(bus.m_dsel), 64'(0));
        check("mrst_cnt", 64'(bus.arb_cnt), 64'(0));
        check("mrst_htrans", 64'(bus.htrans), 64'(0));
        check("mrst_hwdata", 64'(bus.hwdata), 64'(0));
        step();
        @(negedge hclk);
        check("mrst_first", 64'(bus.m_grant), 64'(3'b001));
        check("mrst_cnt1", 64'(bus.arb_cnt), 64'(1));

        // Alternate grants every cycle until the counter wraps
        for (int m = 0; m < 65534; m++) step();
        @(negedge hclk);
        check("wrap_max_cnt", 64'(bus.arb_cnt), 64'(16'hFFFF));
        check("wrap_max_grant", 64'(bus.m_grant), 64'(3'b001));
        step();
        @(negedge hclk);
        check("wrap_zero_cnt", 64'(bus.arb_cnt), 64'(0));
        check("wrap_zero_grant", 64'(bus.m_grant), 64'(3'b010));
        step();
        @(negedge hclk);
        check("wrap_after_cnt", 64'(bus.arb_cnt), 64'(1));
        check("wrap_after_grant", 64'(bus.m_grant), 64'(3'b001));
        check("wrap_after_dsel", 64'(bus.m_dsel), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eva_ahb_arb.md
# eva_ahb_arb

Round-robin AHB-lite arbiter that shares the single AHB master port toward the DUT slave between NUM_M requesters, such as the EVA DPI bus driver and a second stimulus or interrupt-service engine. It grants the bus one owner at a time and multiplexes that owner's address-phase signals onto the slave side. It tracks the data-phase owner separately so hwdata is steered correctly across the pipelined AHB handover. Response signals are broadcast to all requesters.

## Interface
Parameters:
- NUM_M, 2: number of requesters, 2..8.
- AW, 32: address width.
- DW, 32: data width, 32 or 64.

Ports:
- hclk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- m_req  in  NUM_M  per-requester bus request; held high while the requester wants the bus.
- m_htrans  in  2*NUM_M  per-requester htrans; slice i is [2i+1:2i].
- m_hwrite  in  NUM_M  per-requester hwrite.
- m_hsize  in  3*NUM_M  per-requester hsize.
- m_haddr  in  AW*NUM_M  per-requester haddr.
- m_hwdata  in  DW*NUM_M  per-requester hwdata.
- m_grant  out  NUM_M  one-hot address-phase grant, registered.
- m_dsel  out  NUM_M  one-hot data-phase owner, registered.
- m_hready  out  1  broadcast, equals hready_in.
- m_hresp  out  2  broadcast, equals hresp_in.
- m_hrdata  out  DW  broadcast, equals hrdata_in.
- htrans  out  2  to slave.
- hwrite  out  1  to slave.
- hsize  out  3  to slave.
- haddr  out  AW  to slave.
- hwdata  out  DW  to slave.
- hready_in  in  1  from slave.
- hresp_in  in  2  from slave.
- hrdata_in  in  DW  from slave.
- arb_cnt  out  16  count of grant changes; wraps.

## Operation
- State registers:
  - grant (one-hot or zero).
  - last (index of the most recent owner).
  - dsel (one-hot or zero).
  - arb_cnt.
- Address mux, combinational on grant:
  - When grant is nonzero, htrans/hwrite/hsize/haddr come from the granted slice.
  - When grant is zero: htrans=IDLE (2'b00), hwrite=0, hsize=0, haddr=0.
- Data mux, combinational on dsel:
  - When dsel is nonzero, hwdata comes from the selected slice.
  - When dsel is zero, hwdata=0.
- Arbitration point: a rising edge where hready_in=1 and the current owner is releasable.
  - The owner is releasable when grant==0, or the owner's m_htrans is IDLE, or the owner's m_req=0.
  - While the owner drives NONSEQ (2'b10), SEQ (2'b11) or BUSY (2'b01) with m_req=1, the grant is held.
- Winner selection: the first index with m_req=1, searching circularly from last+1. The previous owner therefore has lowest priority.
  - If the winner equals the current owner, grant is unchanged and arb_cnt does not increment.
  - If it differs, grant and last are updated and arb_cnt increments.
- No requests at an arbitration point: grant becomes 0; last is retained.
- Data-phase tracking: on every edge with hready_in=1:
  - dsel <= grant if the slave-side htrans[1]=1, else dsel <= 0.
  - While hready_in=0, dsel and grant hold.
- The arbiter never inspects hresp_in. ERROR handling, including the two-cycle response, is left to the owning requester, which is expected to drive IDLE. It then becomes releasable at the second ERROR cycle (hready_in=1).

## Timing
- Reset values: grant=0, dsel=0, last=NUM_M-1 (so requester 0 wins first), arb_cnt=0.
- Reset output state: htrans=0, hwrite=0, hsize=0, haddr=0, hwdata=0.
- Reset mid-transfer drops grant and dsel on the same edge. No transfer is completed.
- Grant latency: m_req rises in cycle t on an idle bus with hready_in=1. m_grant is asserted from cycle t+1. The requester's NONSEQ appears on htrans in cycle t+1 (combinational pass-through).
- Handover: the old owner's last beat has its address in cycle n and the new grant starts at n+1. The old owner keeps dsel during n+1, and the new owner's address shares that cycle. This gives zero dead cycles when hready_in=1 throughout.
- Wait states freeze grant/dsel/last/arb_cnt, including when requests change.
- Simultaneous requests: exactly one grant, chosen by the circular order above.
- A requester that drops m_req while owning is released at the next hready_in=1 edge.

## Test plan
- Reset, then m_req=2'b11 with both htrans=NONSEQ → m_grant=01 one cycle later; after requester 0 drives IDLE, m_grant=10 next cycle and arb_cnt=2.
- Requester 1 does a 4-beat INCR write with hready_in=1, while requester 0 requests from beat 2 → grant stays 10 through beat 4. m_dsel=10 in the cycle after beat 4, coinciding with m_grant=01. hwdata equals requester 1's data throughout.
- Slave inserts 3 wait states (hready_in=0) during the data phase while a new request arrives → grant, dsel and arb_cnt are unchanged until hready_in returns to 1.
- NUM_M=3, all requesting single NONSEQ then IDLE continuously → grant order 0,1,2,0,1,2. No requester is skipped; arb_cnt increments every arbitration.
- No requests → htrans=IDLE, m_grant=0, hwdata=0. Assert rst_n=0 mid-burst → all outputs at reset values on the next edge, and requester 0 wins first afterward.
- arb_cnt preloaded near wrap via 65536 alternating grants → it wraps to 0 with no side effects.
